pad: RTL and testbench
======================

# pad

Zero-padding stage placed directly upstream of the align stage. It receives row-major groups of `GROUP_SIZE` items for an image of `num_rows` x `num_cols` positions, one image per iteration. It emits the same image framed by optional one-position zero borders on the top, bottom, left and right. Zero groups are generated locally without consuming input. The output handshake matches the align stage's input, so `data_out`, `valid_out` and `avail_in` connect directly to it.

## Interface
- `GROUP_SIZE`, 4, items per group
- `DATA_WIDTH`, 8, bits per item
- `LOG_MAX_ITERS`, 16, width of iteration count
- `LOG_MAX_ROWS`, 16, width of row count
- `LOG_MAX_COLS`, 16, width of column count

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `configure` in 1: load configuration, single-cycle pulse
- `num_iters` in LOG_MAX_ITERS: images to process
- `num_rows` in LOG_MAX_ROWS: unpadded rows
- `num_cols` in LOG_MAX_COLS: unpadded columns
- `pad_top`, `pad_bottom`, `pad_left`, `pad_right` in 1 each: add a one-position zero border on that side
- `data_in` in GROUP_SIZE*DATA_WIDTH: input group
- `valid_in` in 1: input group valid
- `avail_out` out 1: upstream may send
- `data_out` out GROUP_SIZE*DATA_WIDTH: output group
- `valid_out` out 1: output group valid
- `avail_in` in 1: downstream can accept
- `busy` out 1: configured and not finished

## Operation
**Input FIFO**
- 4 slots, first-word-fall-through.
- A write occurs on `valid_in`. A write while full is dropped.
- `almost_full` is set at 3 occupied slots.
- `avail_out = ~almost_full & ~full`.

**Configuration** (`configure` = 1)
- Registers all configuration inputs.
- Computes `rows_p = num_rows + pad_top + pad_bottom` and `cols_p = num_cols + pad_left + pad_right`, each one bit wider than its input.
- Clears `row_r` and `col_r`, and loads `iter_r = num_iters`.
- Sets `busy` only if `num_iters`, `num_rows` and `num_cols` are all nonzero; otherwise `busy` = 0.
- Reconfiguring mid-image aborts the current image. The FIFO is not flushed.

**Pad position**: `row_r < pad_top` or `row_r >= pad_top + num_rows` or `col_r < pad_left` or `col_r >= pad_left + num_cols`.

**Operation fires** when `busy & avail_in & ~configure & (pad_position | ~fifo_empty)`. When it fires:
- `valid_out` = 1.
- `data_out` is zero at a pad position, otherwise the FIFO head.
- The FIFO is popped only at a non-pad position.
- `col_r` increments. At `cols_p-1` it wraps to 0 and `row_r` increments.
- When `row_r` wraps at `rows_p-1`: if `iter_r` is 1, `busy` is cleared; otherwise `iter_r` decrements.

**When no operation fires**: `valid_out` = 0 and `data_out` is all zeros.

**States**
- IDLE (`busy` = 0).
- RUN (`busy` = 1).
- RUN returns to IDLE after the last position of the last iteration.

## Timing
- Reset values:
  - `valid_out` = 0, `data_out` = 0, `busy` = 0, `avail_out` = 1.
  - FIFO empty; all counters 0.
- `valid_out` and `data_out` are combinational from registered state, FIFO head and `avail_in`. A transfer completes in the cycle `valid_out` is high.
- Input-to-output latency is 1 cycle: data written at edge N can leave in cycle N+1 if its position is non-pad and `avail_in` = 1.
- Pad groups are emitted every cycle that `avail_in` = 1, independent of FIFO state.
- Throughput is 1 group/cycle.
- The upstream producer must stop within 1 cycle of `avail_out` falling. The slot reserved by `almost_full` absorbs that in-flight group.
- When a write and a pop occur in the same cycle, occupancy is unchanged. This applies even at 3 occupied slots.
- Changing `pad_*` inputs outside a `configure` pulse has no effect.
- Asynchronous reset mid-image:
  - All outputs return to reset values immediately.
  - The FIFO is emptied.
  - No further `valid_out` until reconfigured.

## Test plan
1. **Full padding, 2x2 image.** Configure `num_rows`=2, `num_cols`=2, all pads 1, 1 iteration; input A,B,C,D; `avail_in` held 1.
   -> 16 outputs: 0,0,0,0, 0,A,B,0, 0,C,D,0, 0,0,0,0.
   -> `busy` falls after the 16th output.
2. **No padding.** Configure 3x1, no pads, 2 iterations; input 6 groups.
   -> 6 pass-through outputs in order; exactly 6 FIFO pops.
3. **Input starvation.** Configure 1x2, `pad_left`=1 only; no input sent.
   -> One zero output.
   -> Output then stalls with `valid_out`=0 until data arrives; subsequent data emitted in order.
4. **Output backpressure.** `avail_in`=0 while upstream sends groups.
   -> FIFO fills and `avail_out` drops at 3 occupied slots.
   -> A 4th group sent in that cycle is stored.
   -> On `avail_in`=1, all 4 groups leave in order.
5. **Degenerate and overlapping configure.** Configure with `num_rows`=0 -> `busy` stays 0, no output. Configure asserted while an operation would fire -> no transfer that cycle, counters restart at 0.
6. **Reset mid-run.** Deassert `rst` during row 1 of an image.
   -> Immediately `valid_out`=0, `busy`=0, `avail_out`=1.
   -> After reconfiguring, the first output is position (0,0).

Source files
------------

// File: rtl/pad_if.sv
// Valid/avail streaming channel carrying one group per transfer.
// The master drives data and valid; the slave reports whether it can accept.
interface pad_stream_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             avail;

    modport master (output data, output valid, input avail);
    modport slave  (input data, input valid, output avail);
endinterface

// File: rtl/pad.sv
// Zero-padding stage: frames each row-major image with optional one-position zero
// borders, feeding the align stage through a 4-slot first-word-fall-through FIFO.
module pad #(
    parameter int GROUP_SIZE    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int LOG_MAX_ITERS = 16,
    parameter int LOG_MAX_ROWS  = 16,
    parameter int LOG_MAX_COLS  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     configure,
    input  logic [LOG_MAX_ITERS-1:0] num_iters,
    input  logic [LOG_MAX_ROWS-1:0]  num_rows,
    input  logic [LOG_MAX_COLS-1:0]  num_cols,
    input  logic                     pad_top,
    input  logic                     pad_bottom,
    input  logic                     pad_left,
    input  logic                     pad_right,
    pad_stream_if.slave              in_bus,
    pad_stream_if.master             out_bus,
    output logic                     busy
);

    localparam int GW = GROUP_SIZE * DATA_WIDTH;
    localparam int RW = LOG_MAX_ROWS + 1;
    localparam int CW = LOG_MAX_COLS + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, next_state;

    logic [GW-1:0] fifo_mem [4];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic          full, almost_full, empty;
    logic          push, pop;
    logic [GW-1:0] head;

    logic [LOG_MAX_ROWS-1:0]  num_rows_r;
    logic [LOG_MAX_COLS-1:0]  num_cols_r;
    logic                     pad_top_r, pad_left_r;
    logic [RW-1:0]            rows_p, row_r;
    logic [CW-1:0]            cols_p, col_r;
    logic [LOG_MAX_ITERS-1:0] iter_r;

    logic cfg_ok, pad_pos, row_last, col_last, last_iter, fire;

    assign full        = (count == 3'd4);
    assign almost_full = (count == 3'd3);
    assign empty       = (count == 3'd0);
    assign head        = fifo_mem[rd_ptr];

    // The almost-full slot absorbs the one group already in flight when avail drops.
    assign in_bus.avail = ~almost_full & ~full;

    assign push = in_bus.valid & ~full;
    assign pop  = fire & ~pad_pos;

    assign cfg_ok = (|num_iters) & (|num_rows) & (|num_cols);

    assign pad_pos = (row_r <  RW'(pad_top_r))
                   | (row_r >= RW'(pad_top_r) + RW'(num_rows_r))
                   | (col_r <  CW'(pad_left_r))
                   | (col_r >= CW'(pad_left_r) + CW'(num_cols_r));

    assign row_last  = (row_r == rows_p - RW'(1));
    assign col_last  = (col_r == cols_p - CW'(1));
    assign last_iter = (iter_r == LOG_MAX_ITERS'(1));

    assign busy = (state == RUN);
    assign fire = busy & out_bus.avail & ~configure & (pad_pos | ~empty);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_bus.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        out_bus.valid = 1'b0;
        out_bus.data  = '0;
        if (configure) begin
            next_state = cfg_ok ? RUN : IDLE;
        end else if (fire && row_last && col_last && last_iter) begin
            next_state = IDLE;
        end
        if (fire) begin
            out_bus.valid = 1'b1;
            out_bus.data  = pad_pos ? '0 : head;
        end
    end

    // Bottom/right pads only matter through the padded extents, so they are not kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_rows_r <= '0;
            num_cols_r <= '0;
            pad_top_r  <= 1'b0;
            pad_left_r <= 1'b0;
            rows_p     <= '0;
            cols_p     <= '0;
            row_r      <= '0;
            col_r      <= '0;
            iter_r     <= '0;
        end else if (configure) begin
            num_rows_r <= num_rows;
            num_cols_r <= num_cols;
            pad_top_r  <= pad_top;
            pad_left_r <= pad_left;
            rows_p     <= RW'(num_rows) + RW'(pad_top) + RW'(pad_bottom);
            cols_p     <= CW'(num_cols) + CW'(pad_left) + CW'(pad_right);
            row_r      <= '0;
            col_r      <= '0;
            iter_r     <= num_iters;
        end else if (fire) begin
            if (col_last) begin
                col_r <= '0;
                if (row_last) begin
                    row_r <= '0;
                    if (!last_iter) begin
                        iter_r <= iter_r - LOG_MAX_ITERS'(1);
                    end
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pad.sv
// Directed self-checking bench for the pad stage: framing, pass-through, starvation,
// backpressure, degenerate/overlapping configure and mid-image reset.
module tb_pad;

    logic        clk;
    logic        rst;
    logic        configure;
    logic [15:0] num_iters, num_rows, num_cols;
    logic        pad_top, pad_bottom, pad_left, pad_right;
    logic        busy;

    pad_stream_if #(.WIDTH(32)) bus_in ();
    pad_stream_if #(.WIDTH(32)) bus_out ();

    int          total;
    int          bad;
    logic [31:0] exp_q[$];
    logic [31:0] in_q[$];

    pad dut (
        .clk        (clk),
        .rst        (rst),
        .configure  (configure),
        .num_iters  (num_iters),
        .num_rows   (num_rows),
        .num_cols   (num_cols),
        .pad_top    (pad_top),
        .pad_bottom (pad_bottom),
        .pad_left   (pad_left),
        .pad_right  (pad_right),
        .in_bus     (bus_in),
        .out_bus    (bus_out),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic vin, input logic [31:0] din, input logic ain);
        @(negedge clk);
        configure     = 1'b0;
        bus_in.valid  = vin;
        bus_in.data   = din;
        bus_out.avail = ain;
        #1;
    endtask

    task automatic doConfigure(input logic [15:0] it, input logic [15:0] r, input logic [15:0] c,
                               input logic pt, input logic pb, input logic pl, input logic pr);
        @(negedge clk);
        configure    = 1'b1;
        num_iters    = it;
        num_rows     = r;
        num_cols     = c;
        pad_top      = pt;
        pad_bottom   = pb;
        pad_left     = pl;
        pad_right    = pr;
        bus_in.valid = 1'b0;
        bus_in.data  = '0;
        #1;
        checkOutput("cfg_no_valid", 32'(bus_out.valid), 32'd0);
    endtask

    // Feeds in_q whenever upstream may send, checks every transfer against exp_q in order.
    task automatic runStream(input string tag, input int cycles);
        int k;
        int sent;
        bit just_done;
        k = 0;
        sent = 0;
        just_done = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            configure = 1'b0;
            if (sent < in_q.size() && bus_in.avail) begin
                bus_in.valid = 1'b1;
                bus_in.data  = in_q[sent];
                sent++;
            end else begin
                bus_in.valid = 1'b0;
                bus_in.data  = '0;
            end
            bus_out.avail = 1'b1;
            #1;
            if (just_done) begin
                checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
                just_done = 0;
            end
            if (bus_out.valid) begin
                if (k < exp_q.size()) begin
                    checkOutput({tag, "_data"}, bus_out.data, exp_q[k]);
                end else begin
                    checkOutput({tag, "_extra"}, 32'(bus_out.valid), 32'd0);
                end
                k++;
                if (k == exp_q.size()) just_done = 1;
            end
        end
        bus_in.valid = 1'b0;
        checkOutput({tag, "_count"}, 32'(k), 32'(exp_q.size()));
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        configure = 1'b0;
        num_iters = '0;
        num_rows = '0;
        num_cols = '0;
        pad_top = 1'b0;
        pad_bottom = 1'b0;
        pad_left = 1'b0;
        pad_right = 1'b0;
        bus_in.valid = 1'b0;
        bus_in.data = '0;
        bus_out.avail = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", 32'(bus_out.valid), 32'd0);
        checkOutput("rst_data", bus_out.data, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_avail", 32'(bus_in.avail), 32'd1);
        rst = 1'b1;

        // Fully padded 2x2 image.
        doConfigure(16'd1, 16'd2, 16'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        in_q  = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4};
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'h0,
                  32'h0, 32'hC1C2C3C4, 32'hD1D2D3D4, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0};
        runStream("t1", 30);

        // No padding, 3x1, two iterations.
        doConfigure(16'd2, 16'd3, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        in_q  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        runStream("t2", 16);

        // Starvation: left pad leaves, then the stream stalls until data arrives.
        doConfigure(16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t3_pad_valid", 32'(bus_out.valid), 32'd1);
        checkOutput("t3_pad_data", bus_out.data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("t3_stall", 32'(bus_out.valid), 32'd0);
        end
        in_q  = '{32'h0000_00E1, 32'h0000_00E2};
        exp_q = '{32'h0000_00E1, 32'h0000_00E2};
        runStream("t3", 8);

        // Backpressure: FIFO fills, avail drops at 3, the in-flight 4th group is kept.
        doConfigure(16'd1, 16'd1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hF0, 1'b0);
        checkOutput("t4_avail0", 32'(bus_in.avail), 32'd1);
        applyStimulus(1'b1, 32'hF1, 1'b0);
        applyStimulus(1'b1, 32'hF2, 1'b0);
        checkOutput("t4_avail2", 32'(bus_in.avail), 32'd1);
        applyStimulus(1'b1, 32'hF3, 1'b0);
        checkOutput("t4_avail3", 32'(bus_in.avail), 32'd0);
        checkOutput("t4_hold_valid", 32'(bus_out.valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t4_avail4", 32'(bus_in.avail), 32'd0);
        in_q.delete();
        exp_q = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
        runStream("t4", 8);

        // Degenerate configure, then a configure that overlaps a firing cycle.
        doConfigure(16'd1, 16'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("t5_deg_busy", 32'(busy), 32'd0);
            checkOutput("t5_deg_valid", 32'(bus_out.valid), 32'd0);
        end
        doConfigure(16'd1, 16'd1, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t5_first_valid", 32'(bus_out.valid), 32'd1);
        checkOutput("t5_first_data", bus_out.data, 32'd0);
        doConfigure(16'd1, 16'd1, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        in_q  = '{32'h0D0D0D00, 32'h0D0D0D01};
        exp_q = '{32'h0, 32'h0, 32'h0D0D0D00, 32'h0D0D0D01};
        runStream("t5", 10);

        // Asynchronous reset while row 1 is leaving.
        doConfigure(16'd1, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h60, 1'b1);
        applyStimulus(1'b1, 32'h61, 1'b1);
        checkOutput("t6_g0", bus_out.data, 32'h60);
        applyStimulus(1'b1, 32'h62, 1'b1);
        applyStimulus(1'b1, 32'h63, 1'b1);
        checkOutput("t6_g2", bus_out.data, 32'h62);
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(bus_out.valid), 32'd0);
        checkOutput("t6_rst_data", bus_out.data, 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_avail", 32'(bus_in.avail), 32'd1);
        @(negedge clk);
        bus_in.valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("t6_quiet", 32'(bus_out.valid), 32'd0);
        end
        doConfigure(16'd1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        in_q  = '{32'h7777_0001};
        exp_q = '{32'h0, 32'h7777_0001};
        runStream("t6", 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
